// File: rtl/readout_line_ctrl_pkg.sv
// ============================================================================
// readout_line_ctrl_pkg : shared sequencer types and width defaults.  Rev 1.0
// ============================================================================
`default_nettype none

package readout_line_ctrl_pkg;

  localparam int LEN_W_DEF = 19;
  localparam int PER_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STV  = 2'd1,
    ST_LINE = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/readout_line_ctrl.sv
// ============================================================================
// readout_line_ctrl : per-frame STV pulse and line timing for the readout phase.
// Rev 1.0
// ============================================================================
`default_nettype none

module readout_line_ctrl
  import readout_line_ctrl_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk_20mhz,
  input  logic             rst_n_20mhz,
  input  logic             readout_enable_i,
  input  logic             stv_mask_i,
  input  logic             csi_mask_i,
  input  logic [LEN_W-1:0] data_length_i,
  input  logic [PER_W-1:0] line_period_i,
  output logic             stv_o,
  output logic             line_start_o,
  output logic [LEN_W-1:0] line_idx_o,
  output logic             line_active_o,
  output logic             csi_valid_o,
  output logic             busy_o,
  output logic             readout_done_o,
  output logic             abort_o
);

  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic             armed_q, armed_d;
  logic             stv_mask_q, stv_mask_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] line_idx_q, line_idx_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [PER_W-1:0] cnt_q, cnt_d;

  logic start_w;
  logic last_cyc_w;
  logic last_line_w;

  // armed_q keeps an enable already high at reset release from counting as an edge
  assign start_w     = (state_q == ST_IDLE) && readout_enable_i && !enable_q && armed_q;
  assign last_cyc_w  = (cnt_q == period_q - PER_W'(1));
  assign last_line_w = (line_idx_q == len_q - LEN_W'(1));

  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_w) begin
          state_d = (data_length_i == '0) ? ST_DONE : ST_STV;
        end
      end
      ST_STV: begin
        state_d = readout_enable_i ? ST_LINE : ST_IDLE;
      end
      ST_LINE: begin
        if (!readout_enable_i) begin
          state_d = ST_IDLE;
        end else if (last_cyc_w && last_line_w) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enable_d   = readout_enable_i;
    armed_d    = armed_q | !readout_enable_i;
    stv_mask_d = stv_mask_q;
    len_d      = len_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    line_idx_d = line_idx_q;
    if (start_w) begin
      stv_mask_d = stv_mask_i;
      len_d      = data_length_i;
      period_d   = (line_period_i == '0) ? PER_W'(1) : line_period_i;
      cnt_d      = '0;
      line_idx_d = '0;
    end else if (state_q == ST_LINE) begin
      if (!readout_enable_i) begin
        cnt_d = '0;
      end else if (last_cyc_w) begin
        cnt_d = '0;
        // on the final line the index stays put so it reads back after the frame
        if (!last_line_w) begin
          line_idx_d = line_idx_q + LEN_W'(1);
        end
      end else begin
        cnt_d = cnt_q + PER_W'(1);
      end
    end
  end

  always_ff @(posedge clk_20mhz or negedge rst_n_20mhz) begin
    if (!rst_n_20mhz) begin
      enable_q   <= 1'b0;
      armed_q    <= 1'b0;
      stv_mask_q <= 1'b0;
      len_q      <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      line_idx_q <= '0;
    end else begin
      enable_q   <= enable_d;
      armed_q    <= armed_d;
      stv_mask_q <= stv_mask_d;
      len_q      <= len_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      line_idx_q <= line_idx_d;
    end
  end

  always_comb begin
    stv_o          = 1'b0;
    line_start_o   = 1'b0;
    line_active_o  = 1'b0;
    csi_valid_o    = 1'b0;
    busy_o         = (state_q != ST_IDLE);
    readout_done_o = (state_q == ST_DONE);
    abort_o        = 1'b0;
    line_idx_o     = line_idx_q;
    case (state_q)
      ST_STV: begin
        stv_o   = !stv_mask_q;
        abort_o = !readout_enable_i;
      end
      ST_LINE: begin
        line_active_o = 1'b1;
        line_start_o  = (cnt_q == '0);
        csi_valid_o   = !csi_mask_i;
        abort_o       = !readout_enable_i;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_readout_line_ctrl.sv
// ============================================================================
// tb_readout_line_ctrl : directed frame scenarios with per-cycle output capture.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_readout_line_ctrl;

  localparam int LEN_W = 19;
  localparam int PER_W = 16;

  logic             clk_20mhz = 1'b0;
  logic             rst_n_20mhz;
  logic             readout_enable_i;
  logic             stv_mask_i;
  logic             csi_mask_i;
  logic [LEN_W-1:0] data_length_i;
  logic [PER_W-1:0] line_period_i;
  logic             stv_o;
  logic             line_start_o;
  logic [LEN_W-1:0] line_idx_o;
  logic             line_active_o;
  logic             csi_valid_o;
  logic             busy_o;
  logic             readout_done_o;
  logic             abort_o;

  int total  = 0;
  int passed = 0;

  // bit k of each vector = output value in the k-th cycle after the start edge
  logic [31:0] stv_v, ls_v, done_v, busy_v, abort_v, csi_v;
  int mut_kind = 0;
  int mut_at   = 0;

  readout_line_ctrl #(.LEN_W(LEN_W), .PER_W(PER_W)) dut (
    .clk_20mhz       (clk_20mhz),
    .rst_n_20mhz     (rst_n_20mhz),
    .readout_enable_i(readout_enable_i),
    .stv_mask_i      (stv_mask_i),
    .csi_mask_i      (csi_mask_i),
    .data_length_i   (data_length_i),
    .line_period_i   (line_period_i),
    .stv_o           (stv_o),
    .line_start_o    (line_start_o),
    .line_idx_o      (line_idx_o),
    .line_active_o   (line_active_o),
    .csi_valid_o     (csi_valid_o),
    .busy_o          (busy_o),
    .readout_done_o  (readout_done_o),
    .abort_o         (abort_o)
  );

  always #25 clk_20mhz = ~clk_20mhz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic capture(input int n);
    stv_v = '0; ls_v = '0; done_v = '0; busy_v = '0; abort_v = '0; csi_v = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk_20mhz);
      if (mut_kind == 1 && k == mut_at) begin
        data_length_i = 9; line_period_i = 7; stv_mask_i = 1'b1;
      end
      if (mut_kind == 2 && k == mut_at) readout_enable_i = 1'b0;
      if (mut_kind == 3 && k == mut_at) csi_mask_i = 1'b1;
      if (mut_kind == 3 && k == mut_at + 2) csi_mask_i = 1'b0;
      #1;
      stv_v[k]   = stv_o;
      ls_v[k]    = line_start_o;
      done_v[k]  = readout_done_o;
      busy_v[k]  = busy_o;
      abort_v[k] = abort_o;
      csi_v[k]   = csi_valid_o;
    end
    mut_kind = 0;
  endtask

  task automatic start_frame(input int len, input int per, input logic smask);
    @(negedge clk_20mhz);
    data_length_i    = LEN_W'(len);
    line_period_i    = PER_W'(per);
    stv_mask_i       = smask;
    readout_enable_i = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    readout_enable_i = 1'b0;
    repeat (n) @(negedge clk_20mhz);
  endtask

  initial begin
    rst_n_20mhz = 1'b0; readout_enable_i = 1'b0; stv_mask_i = 1'b0; csi_mask_i = 1'b0;
    data_length_i = '0; line_period_i = '0;
    repeat (2) @(negedge clk_20mhz);
    chk("reset_outs", {31'd0, stv_o | line_start_o | line_active_o | csi_valid_o |
                       busy_o | readout_done_o | abort_o}, 32'd0);
    chk("reset_idx", 32'(line_idx_o), 32'd0);
    rst_n_20mhz = 1'b1;
    idle_cycles(3);

    // length 3, period 4; inputs changed mid-frame must not matter
    mut_kind = 1; mut_at = 3;
    start_frame(3, 4, 1'b0);
    capture(16);
    chk("a_stv", stv_v, 32'h0000_0002);
    chk("a_line_start", ls_v, 32'h0000_0444);
    chk("a_done", done_v, 32'h0000_4000);
    chk("a_busy", busy_v, 32'h0000_7FFE);
    chk("a_abort", abort_v, 32'h0);
    chk("a_idx_hold", 32'(line_idx_o), 32'd2);
    idle_cycles(2);
    chk("a_idx_idle", 32'(line_idx_o), 32'd2);

    // length 0: straight to DONE
    start_frame(0, 5, 1'b0);
    capture(4);
    chk("b_done", done_v, 32'h0000_0002);
    chk("b_stv", stv_v, 32'h0);
    chk("b_line_start", ls_v, 32'h0);
    chk("b_busy", busy_v, 32'h0000_0002);
    chk("b_idx_clear", 32'(line_idx_o), 32'd0);
    idle_cycles(2);

    // period 0 acts as 1
    start_frame(2, 0, 1'b0);
    capture(6);
    chk("c_stv", stv_v, 32'h0000_0002);
    chk("c_line_start", ls_v, 32'h0000_000C);
    chk("c_done", done_v, 32'h0000_0010);
    chk("c_idx", 32'(line_idx_o), 32'd1);
    idle_cycles(2);

    // enable drops during line 1 of 5
    mut_kind = 2; mut_at = 7;
    start_frame(5, 4, 1'b0);
    capture(10);
    chk("d_abort", abort_v, 32'h0000_0080);
    chk("d_busy", busy_v, 32'h0000_00FE);
    chk("d_done", done_v, 32'h0);
    chk("d_idx", 32'(line_idx_o), 32'd1);
    idle_cycles(2);

    // stv masked, csi mask toggled mid-line
    mut_kind = 3; mut_at = 4;
    start_frame(1, 6, 1'b1);
    capture(10);
    chk("e_stv", stv_v, 32'h0);
    chk("e_csi", csi_v, 32'h0000_00CC);
    chk("e_line_start", ls_v, 32'h0000_0004);
    chk("e_done", done_v, 32'h0000_0100);
    idle_cycles(2);

    // reset mid-LINE with enable held high
    start_frame(5, 4, 1'b0);
    capture(4);
    chk("f_pre_busy", {31'd0, line_active_o}, 32'd1);
    #5 rst_n_20mhz = 1'b0;
    #1;
    chk("f_rst_outs", {25'd0, stv_o, line_start_o, line_active_o, csi_valid_o,
                       busy_o, readout_done_o, abort_o}, 32'd0);
    chk("f_rst_idx", 32'(line_idx_o), 32'd0);
    @(negedge clk_20mhz);
    rst_n_20mhz = 1'b1;
    capture(6);
    chk("f_no_restart_busy", busy_v, 32'h0);
    chk("f_no_restart_stv", stv_v, 32'h0);
    idle_cycles(2);
    start_frame(5, 4, 1'b0);
    capture(3);
    chk("f_restart_stv", stv_v, 32'h0000_0002);
    chk("f_restart_busy", busy_v, 32'h0000_000E);
    idle_cycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/readout_line_ctrl.md
READOUT_LINE_CTRL -- requirements
Module: readout_line_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 19, meaning line-count width (matches sequencer data length).
REQ-002 SHALL have parameter PER_W, default 16, meaning line-period counter width.
REQ-003 SHALL have port clk_20mhz  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_20mhz  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port readout_enable_i  in  1  readout phase level from sequencer FSM.
REQ-006 SHALL have port stv_mask_i  in  1  suppress STV pulse for this frame.
REQ-007 SHALL have port csi_mask_i  in  1  suppress CSI data-valid.
REQ-008 SHALL have port data_length_i  in  LEN_W  lines per frame.
REQ-009 SHALL have port line_period_i  in  PER_W  clk_20mhz cycles per line.
REQ-010 SHALL have port stv_o  out  1  one-cycle gate start pulse.
REQ-011 SHALL have port line_start_o  out  1  one-cycle pulse at first cycle of each line.
REQ-012 SHALL have port line_idx_o  out  LEN_W  current line index, 0-based.
REQ-013 SHALL have port line_active_o  out  1  high during LINE state.
REQ-014 SHALL have port csi_valid_o  out  1  line_active_o and not csi_mask_i.
REQ-015 SHALL have port busy_o  out  1  high in any state except IDLE.
REQ-016 SHALL have port readout_done_o  out  1  one-cycle frame-complete pulse.
REQ-017 SHALL have port abort_o  out  1  one-cycle pulse on premature enable drop.

Function
REQ-018 SHALL implement states IDLE, STV, LINE, DONE.
REQ-019 SHALL detect rising edge of readout_enable_i via one registered copy; start occurs in cycle after the edge is sampled.
REQ-020 SHALL latch data_length_i, line_period_i, stv_mask_i at start; later input changes ignored until next start.
REQ-021 SHALL treat latched line_period 0 as 1.
REQ-022 SHALL, at start with length 0, go IDLE->DONE directly: no stv_o, no lines, readout_done_o next cycle.
REQ-023 SHALL, at start with length nonzero, enter STV for exactly 1 cycle; stv_o = not latched stv_mask during that cycle.
REQ-024 SHALL, in LINE, run cycle counter 0..period-1; line_start_o high when counter==0.
REQ-025 SHALL, at counter==period-1: if line_idx_o==length-1 go DONE, else increment line_idx_o and clear counter.
REQ-026 SHALL, in DONE, assert readout_done_o for 1 cycle and return to IDLE.
REQ-027 SHALL, if readout_enable_i is low while in STV or LINE, go IDLE next cycle, pulse abort_o once, not pulse readout_done_o.
REQ-028 SHALL hold line_idx_o at final value in IDLE and clear it to 0 at start.
REQ-029 SHALL ignore a rising edge that occurs while busy_o is high; no queued restart.
REQ-030 SHALL drive csi_valid_o combinationally from line_active_o and live csi_mask_i.
REQ-031 SHALL total frame duration, start-to-done, = 1 + length*max(period,1) + 1 cycles.

Reset
REQ-032 SHALL on rst_n_20mhz low force IDLE, all outputs 0, counters 0, edge register 0, including mid-frame; no abort_o on reset.
REQ-033 SHALL not start a frame if readout_enable_i is already high when reset releases (edge register must see low first).

Structure
REQ-034 SHALL place the state enum and LEN_W/PER_W defaults in the shared sequencer package.
REQ-035 SHALL be a single module; no sub-module required.

Verification
REQ-036 length=3, period=4, stv_mask=0: stv_o 1 cycle, line_start_o at cycles 2,6,10 after start, readout_done_o at cycle 14.
REQ-037 length=0: readout_done_o 1 cycle after start, stv_o and line_start_o never assert.
REQ-038 period=0, length=2: lines 1 cycle each, line_start_o high 2 consecutive cycles.
REQ-039 enable drops during line 1 of 5: abort_o single pulse, busy_o low next cycle, no readout_done_o.
REQ-040 stv_mask=1, csi_mask toggled mid-line: stv_o stays 0, csi_valid_o tracks mask same cycle.
REQ-041 reset asserted mid-LINE with enable held high: all outputs 0; after release no new frame until enable goes low then high.
